// File: rtl/serial_adder.sv
// Digit-serial add/subtract: WIDTH/DIGIT digits per operation, LSB digit first, done N edges after accept.
// ready is low while running; start is ignored (not queued) until the done cycle, when a new start is accepted.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [DIGIT:0]   dsum;

  // Operands shift right each digit so the active digit is always at the bottom;
  // result digits enter at the top and land in place after N shifts.
  assign dsum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign res_d = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= dsum[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            sum_q   <= res_d;
            cout_q  <= dsum[DIGIT];
            ovf_q   <= (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT 1, 4, 2 at WIDTH 8) share stimulus and
// are each compared every cycle against a transaction-level arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       ready_w [3];
  logic       done_w  [3];
  logic       cout_w  [3];
  logic       ovf_w   [3];
  logic [7:0] sum_w   [3];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  function automatic int ndig(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: an accepted operation is a plain 9-bit addition whose result
  // appears after N edges; while busy the instance ignores start.
  int         m_rem  [3];
  logic       m_done [3];
  logic [7:0] m_sum  [3];
  logic       m_cout [3];
  logic       m_ovf  [3];
  logic [7:0] p_sum  [3];
  logic       p_cout [3];
  logic       p_ovf  [3];
  logic [7:0] m_be;
  logic [8:0] m_full;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_rem[i] = 0; m_done[i] = 1'b0;
        m_sum[i] = 8'h00; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_rem[i] > 0) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_sum[i] = p_sum[i]; m_cout[i] = p_cout[i]; m_ovf[i] = p_ovf[i];
            m_done[i] = 1'b1;
          end
        end else if (start) begin
          m_be      = sub ? ~b : b;
          m_full    = {1'b0, a} + {1'b0, m_be} + 9'(sub ? 1'b1 : cin);
          p_sum[i]  = m_full[7:0];
          p_cout[i] = m_full[8];
          p_ovf[i]  = (a[7] == m_be[7]) && (m_full[7] != a[7]);
          m_rem[i]  = ndig(i);
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++)
      check($sformatf("cycle inst%0d {rdy,done,cout,ovf,sum}", i),
            64'({ready_w[i], done_w[i], cout_w[i], ovf_w[i], sum_w[i]}),
            64'({m_rem[i] == 0, m_done[i], m_cout[i], m_ovf[i], m_sum[i]}));
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input logic tc,
                        input int inst, output int lat, output logic [7:0] rs,
                        output logic rc, output logic ro);
    logic got;
    got = 1'b0; rs = 8'hxx; rc = 1'bx; ro = 1'bx;
    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done_w[inst]) begin
        got = 1'b1; rs = sum_w[inst]; rc = cout_w[inst]; ro = ovf_w[inst];
      end
    end
    if (!got) check("done timeout", 64'(got), 64'(1));
    repeat (10) @(negedge clk);
  endtask

  int         lat;
  logic [7:0] rs;
  logic       rc, ro;
  int         ndone;
  int         last, cyc;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset state", 64'({ready_w[0], done_w[0], cout_w[0], ovf_w[0], sum_w[0]}), 64'(12'h800));

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, lat, rs, rc, ro);
    check("FF+01 latency", 64'(lat), 64'(8));
    check("FF+01 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'h00, 1'b1, 1'b0}));

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, lat, rs, rc, ro);
    check("7F+01 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'h80, 1'b0, 1'b1}));
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 0, lat, rs, rc, ro);
    check("05-07 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'hFE, 1'b0, 1'b0}));
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0, lat, rs, rc, ro);
    check("07-05 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'h02, 1'b1, 1'b0}));
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 0, lat, rs, rc, ro);
    check("80-01 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'h7F, 1'b1, 1'b1}));

    run_op(8'h3C, 8'h45, 1'b0, 1'b1, 1, lat, rs, rc, ro);
    check("3C+45+1 d4 latency", 64'(lat), 64'(2));
    check("3C+45+1 d4 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'h82, 1'b0, 1'b1}));

    run_op(8'h80, 8'h80, 1'b0, 1'b0, 2, lat, rs, rc, ro);
    check("80+80 d2 latency", 64'(lat), 64'(4));
    check("80+80 d2 {sum,cout,ovf}", 64'({rs, rc, ro}), 64'({8'h00, 1'b1, 1'b1}));

    // Start pulses with fresh operands while the DIGIT=1 instance is running.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ndone = 0; rs = 8'hxx;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_w[0]) begin ndone++; rs = sum_w[0]; end
      if (k >= 1 && k <= 5) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom);
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      end else start = 1'b0;
    end
    check("ignored starts: done count", 64'(ndone), 64'(1));
    check("ignored starts: sum", 64'(rs), 64'(8'h46));
    repeat (10) @(negedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'h21; b = 8'h43; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy before reset", 64'(ready_w[0]), 64'(0));
    rst_n = 1'b0;
    #1;
    check("reset mid-run ready", 64'(ready_w[0]), 64'(1));
    check("reset mid-run sum", 64'(sum_w[0]), 64'(0));
    check("reset mid-run sum d2", 64'(sum_w[2]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_w[0]) ndone++;
    end
    check("no done after abort", 64'(ndone), 64'(0));
    run_op(8'h21, 8'h43, 1'b0, 1'b1, 0, lat, rs, rc, ro);
    check("after reset 21+43+1", 64'({rs, rc, ro}), 64'({8'h65, 1'b0, 1'b0}));

    // Back-to-back operations with start held high and random operands.
    @(negedge clk);
    start = 1'b1; a = 8'($urandom); b = 8'($urandom);
    sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    ndone = 0; last = -1; cyc = 0;
    while (ndone < 1000 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (done_w[2]) begin
        if (last >= 0) check("b2b period", 64'(cyc - last), 64'(5));
        last = cyc;
        ndone++;
      end
      a = 8'($urandom); b = 8'($urandom);
      sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    end
    check("b2b op count", 64'(ndone), 64'(1000));
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
